// File: rtl/dspl_decoder_nexys.sv
// dspl_decoder_nexys: rebuilds digit words d1..d8 from the multiplexed an/dec_ddp display lines
module dspl_decoder_nexys #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] an,
    input  logic [7:0] dec_ddp,
    output logic [5:0] d1,
    output logic [5:0] d2,
    output logic [5:0] d3,
    output logic [5:0] d4,
    output logic [5:0] d5,
    output logic [5:0] d6,
    output logic [5:0] d7,
    output logic [5:0] d8,
    output logic       frame_valid,
    output logic       glyph_err,
    output logic       an_err
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CYCLES);
    localparam logic [SW-1:0] STAB_PRE = SW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, COLLECT, PUBLISH} state_t;

    logic [15:0]     sync1_q, sync2_q, prev_q;
    logic [SW-1:0]   stab_cnt_q, stab_cnt_d;
    logic [TW-1:0]   to_cnt_q, to_cnt_d;
    state_t          state_q, state_d;
    logic [7:0]      seen_q, seen_d;
    logic [7:0][5:0] shadow_q, shadow_d, d_q, d_d, frame;
    logic            frame_valid_q, frame_valid_d;
    logic            glyph_err_q, glyph_err_d;
    logic            an_err_q, an_err_d;
    logic [7:0]      an_s;
    logic [6:0]      seg_s;
    logic            dp_s;
    logic [3:0]      zeros, hex;
    logic [2:0]      idx;
    logic            changed, stable_hit, cap, hit, wrap, timeout, publish;
    logic [5:0]      slot;

    function automatic logic [4:0] glyph_lookup(input logic [6:0] seg);
        case (seg)
            7'b0000001: return 5'h10;
            7'b1001111: return 5'h11;
            7'b0010010: return 5'h12;
            7'b0000110: return 5'h13;
            7'b1001100: return 5'h14;
            7'b0100100: return 5'h15;
            7'b0100000: return 5'h16;
            7'b0001111: return 5'h17;
            7'b0000000: return 5'h18;
            7'b0000100: return 5'h19;
            7'b0001000: return 5'h1A;
            7'b1100000: return 5'h1B;
            7'b0110001: return 5'h1C;
            7'b1000010: return 5'h1D;
            7'b0110000: return 5'h1E;
            7'b0111000: return 5'h1F;
            default:    return 5'h00;
        endcase
    endfunction

    assign {an_s, seg_s, dp_s} = sync2_q;

    always_comb begin
        zeros = '0;
        idx = '0;
        for (int k = 0; k < 8; k++) if (!an_s[k]) begin
            zeros = zeros + 4'd1;
            idx = 3'(k);
        end
        changed = sync2_q != prev_q;
        stab_cnt_d = changed ? '0 : (stab_cnt_q == STAB_MAX ? STAB_MAX : stab_cnt_q + SW'(1));
        stable_hit = !changed && stab_cnt_q == STAB_PRE;
        cap = stable_hit && zeros == 4'd1;
        an_err_d = stable_hit && zeros > 4'd1;
        {hit, hex} = glyph_lookup(seg_s);
        glyph_err_d = cap && !hit;
        slot = {1'b1, hit ? hex : 4'h0, ~dp_s};
        timeout = !cap && to_cnt_q == TO_MAX;
        to_cnt_d = (cap || timeout) ? '0 : to_cnt_q + TW'(1);
        wrap = cap && seen_q[idx];
        publish = wrap || timeout;
        frame = '0;
        for (int k = 0; k < 8; k++) frame[k] = seen_q[k] ? shadow_q[k] : 6'd0;
        d_d = publish ? frame : d_q;
        frame_valid_d = publish;
        seen_d = timeout ? '0 : wrap ? 8'b1 << idx : cap ? seen_q | (8'b1 << idx) : seen_q;
        shadow_d = shadow_q;
        if (cap) shadow_d[idx] = slot;
        state_d = cap ? (wrap ? PUBLISH : COLLECT) :
                  timeout ? (state_q == IDLE ? IDLE : PUBLISH) :
                  state_q == PUBLISH ? COLLECT : state_q;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q       <= '1;
            sync2_q       <= '1;
            prev_q        <= '1;
            stab_cnt_q    <= '0;
            to_cnt_q      <= '0;
            state_q       <= IDLE;
            seen_q        <= '0;
            shadow_q      <= '0;
            d_q           <= '0;
            frame_valid_q <= 1'b0;
            glyph_err_q   <= 1'b0;
            an_err_q      <= 1'b0;
        end else begin
            sync1_q       <= {an, dec_ddp};
            sync2_q       <= sync1_q;
            prev_q        <= sync2_q;
            stab_cnt_q    <= stab_cnt_d;
            to_cnt_q      <= to_cnt_d;
            state_q       <= state_d;
            seen_q        <= seen_d;
            shadow_q      <= shadow_d;
            d_q           <= d_d;
            frame_valid_q <= frame_valid_d;
            glyph_err_q   <= glyph_err_d;
            an_err_q      <= an_err_d;
        end
    end

    assign {d8, d7, d6, d5, d4, d3, d2, d1} = d_q;
    assign frame_valid = frame_valid_q;
    assign glyph_err   = glyph_err_q;
    assign an_err      = an_err_q;
endmodule

// File: tb/tb_dspl_decoder_nexys.sv
// tb_dspl_decoder_nexys: directed display scans checked every cycle against a frame-level decoder model
module tb_dspl_decoder_nexys;
    localparam int S = 4;
    localparam int T = 200;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] an = 8'hFF;
    logic [7:0] dec_ddp = 8'hFF;
    logic [5:0] d1, d2, d3, d4, d5, d6, d7, d8;
    logic       frame_valid, glyph_err, an_err;
    logic [7:0][5:0] dout;

    int checks = 0;
    int failures = 0;
    int fv_cnt = 0, ge_cnt = 0, ae_cnt = 0;

    logic [6:0] glyph [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                               7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                               7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
                               7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000};

    logic [15:0] m_prev, p0_x, p1_x;
    int          m_run, m_idle;
    logic        p0_v, p1_v;
    logic [7:0]  m_seen;
    logic [5:0]  m_shadow [8];
    logic [5:0]  m_d [8];
    logic        m_fv, m_ge, m_ae;

    dspl_decoder_nexys #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clock(clock), .reset(reset), .an(an), .dec_ddp(dec_ddp),
        .d1(d1), .d2(d2), .d3(d3), .d4(d4), .d5(d5), .d6(d6), .d7(d7), .d8(d8),
        .frame_valid(frame_valid), .glyph_err(glyph_err), .an_err(an_err)
    );

    assign dout = {d8, d7, d6, d5, d4, d3, d2, d1};

    always #5 clock = ~clock;

    function automatic logic [7:0] seg(input int h, input logic dp);
        return {glyph[h], ~dp};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_prev = '1; m_run = 0; m_idle = 0;
        p0_v = 1'b0; p1_v = 1'b0; p0_x = '1; p1_x = '1;
        m_seen = '0; m_fv = 1'b0; m_ge = 1'b0; m_ae = 1'b0;
        for (int k = 0; k < 8; k++) begin
            m_shadow[k] = '0;
            m_d[k] = '0;
        end
    endtask

    task automatic model_publish();
        for (int k = 0; k < 8; k++) m_d[k] = m_seen[k] ? m_shadow[k] : 6'd0;
        m_fv = 1'b1;
        m_seen = '0;
    endtask

    // A digit held for S+1 samples is acted on two clocks after its last needed sample.
    task automatic model_apply(input logic ev, input logic [15:0] x);
        int zeros, idx, hex;
        logic cap;
        m_fv = 1'b0; m_ge = 1'b0; m_ae = 1'b0;
        zeros = 0; idx = 0; cap = 1'b0; hex = -1;
        if (ev) begin
            for (int k = 0; k < 8; k++) if (!x[8+k]) begin
                zeros++;
                idx = k;
            end
            m_ae = zeros > 1;
            cap = zeros == 1;
        end
        if (cap) begin
            for (int h = 0; h < 16; h++) if (glyph[h] == x[7:1]) hex = h;
            m_ge = hex < 0;
            if (m_seen[idx]) model_publish();
            m_shadow[idx] = {1'b1, hex < 0 ? 4'h0 : 4'(hex), ~x[0]};
            m_seen[idx] = 1'b1;
            m_idle = 0;
        end else if (m_idle == T) begin
            model_publish();
            m_idle = 0;
        end else m_idle++;
    endtask

    task automatic model_edge();
        logic [15:0] x;
        x = {an, dec_ddp};
        m_run = (x == m_prev) ? m_run + 1 : 1;
        m_prev = x;
        model_apply(p1_v, p1_x);
        p1_v = p0_v; p1_x = p0_x;
        p0_v = m_run == S + 1; p0_x = x;
    endtask

    task automatic step();
        @(posedge clock);
        if (reset) model_edge(); else model_reset();
        @(negedge clock);
        for (int k = 0; k < 8; k++) check($sformatf("d%0d", k + 1), 32'(dout[k]), 32'(m_d[k]));
        check("frame_valid", 32'(frame_valid), 32'(m_fv));
        check("glyph_err", 32'(glyph_err), 32'(m_ge));
        check("an_err", 32'(an_err), 32'(m_ae));
        fv_cnt += int'(frame_valid);
        ge_cnt += int'(glyph_err);
        ae_cnt += int'(an_err);
    endtask

    task automatic hold(input logic [7:0] a, input logic [7:0] d, input int n);
        an = a;
        dec_ddp = d;
        repeat (n) step();
    endtask

    task automatic scan();
        for (int i = 0; i < 8; i++) hold(~(8'b1 << i), seg(i + 1, i == 2), 20);
    endtask

    initial begin
        int n;
        model_reset();
        repeat (3) step();
        check("rst_d1", 32'(d1), 0);
        check("rst_fv", 32'(frame_valid), 0);
        reset = 1'b1;

        fv_cnt = 0;
        scan();
        scan();
        check("t1_fv_count", fv_cnt, 1);
        check("t1_d3", 32'(d3), 32'(6'b1_0011_1));
        check("t1_d1", 32'(d1), 32'(6'b1_0001_0));
        check("t1_d8", 32'(d8), 32'(6'b1_1000_0));

        fv_cnt = 0;
        repeat (3) begin
            hold(8'hFE, seg(14, 1'b0), 20);
            hold(8'hFD, seg(15, 1'b0), 20);
        end
        check("t2_fv_count", fv_cnt, 3);
        check("t2_d1", 32'(d1), 32'(6'b1_1110_0));
        check("t2_d2", 32'(d2), 32'(6'b1_1111_0));
        check("t2_d3", 32'(d3), 0);
        check("t2_d8", 32'(d8), 0);

        ge_cnt = 0;
        hold(8'hFB, 8'b1111110_1, 20);
        hold(8'hFB, seg(5, 1'b0), 20);
        check("t3_glyph_err_count", ge_cnt, 1);
        check("t3_d3", 32'(d3), 32'(6'b1_0000_0));

        ae_cnt = 0;
        fv_cnt = 0;
        hold(8'hFC, seg(8, 1'b0), 10);
        hold(8'hFF, 8'hFF, 5);
        check("t4_an_err_count", ae_cnt, 1);
        check("t4_fv_count", fv_cnt, 0);
        check("t4_d3", 32'(d3), 32'(6'b1_0000_0));

        ae_cnt = 0;
        ge_cnt = 0;
        hold(8'hF7, seg(9, 1'b0), 20);
        hold(8'hEF, seg(10, 1'b0), 2);
        hold(8'hFF, 8'hFF, 20);
        check("t5_an_err_count", ae_cnt, 0);
        check("t5_glyph_err_count", ge_cnt, 0);

        fv_cnt = 0;
        n = 0;
        while (fv_cnt == 0 && n < T + 50) begin
            step();
            n++;
        end
        check("t6_first_timeout", fv_cnt, 1);
        check("t6_d3", 32'(d3), 32'(6'b1_0101_0));
        check("t6_d4", 32'(d4), 32'(6'b1_1001_0));
        check("t6_d5", 32'(d5), 0);
        n = 0;
        while (fv_cnt == 1 && n < T + 50) begin
            step();
            n++;
        end
        check("t6_timeout_period", n, T + 1);
        check("t6_blank_frame", 32'(dout), 0);

        fv_cnt = 0;
        scan();
        hold(8'hFE, seg(1, 1'b0), 20);
        check("t7_fv_count", fv_cnt, 1);
        check("t7_pre_d2", 32'(d2), 32'(6'b1_0010_0));
        hold(8'hFD, seg(2, 1'b0), 10);
        reset = 1'b0;
        an = 8'hFF;
        dec_ddp = 8'hFF;
        #1;
        check("t7_async_d", 32'(dout), 0);
        check("t7_async_flags", 32'({frame_valid, glyph_err, an_err}), 0);
        repeat (3) step();
        reset = 1'b1;
        fv_cnt = 0;
        scan();
        check("t7_first_pass_fv", fv_cnt, 0);
        scan();
        check("t7_fv_count", fv_cnt, 1);
        check("t7_d3", 32'(d3), 32'(6'b1_0011_1));
        check("t7_d1", 32'(d1), 32'(6'b1_0001_0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
